// File: rtl/bsg_axil_reg_responder.sv
// rtl/bsg_axil_reg_responder.sv - AXI4-Lite subordinate exposing a bank of word-wide control/status registers
module bsg_axil_reg_responder #(
    parameter int              axil_data_width_p = 32,
    parameter int              axil_addr_width_p = 32,
    parameter int              els_p             = 8,
    parameter longint unsigned base_addr_p       = 0
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [axil_addr_width_p-1:0]         s_axil_awaddr_i,
    input  logic [2:0]                           s_axil_awprot_i,
    input  logic                                 s_axil_awvalid_i,
    output logic                                 s_axil_awready_o,
    input  logic [axil_data_width_p-1:0]         s_axil_wdata_i,
    input  logic [axil_data_width_p/8-1:0]       s_axil_wstrb_i,
    input  logic                                 s_axil_wvalid_i,
    output logic                                 s_axil_wready_o,
    output logic [1:0]                           s_axil_bresp_o,
    output logic                                 s_axil_bvalid_o,
    input  logic                                 s_axil_bready_i,
    input  logic [axil_addr_width_p-1:0]         s_axil_araddr_i,
    input  logic [2:0]                           s_axil_arprot_i,
    input  logic                                 s_axil_arvalid_i,
    output logic                                 s_axil_arready_o,
    output logic [axil_data_width_p-1:0]         s_axil_rdata_o,
    output logic [1:0]                           s_axil_rresp_o,
    output logic                                 s_axil_rvalid_o,
    input  logic                                 s_axil_rready_i,
    output logic [els_p*axil_data_width_p-1:0]   reg_o,
    output logic [els_p-1:0]                     reg_w_v_o
);

    localparam int                         dw_lp       = axil_data_width_p;
    localparam int                         aw_lp       = axil_addr_width_p;
    localparam int                         strb_w_lp   = dw_lp / 8;
    localparam int                         lg_bytes_lp = $clog2(strb_w_lp);
    localparam int                         lg_els_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [aw_lp-1:0]           base_lp     = aw_lp'(base_addr_p);
    localparam logic [aw_lp-1:0]           els_lp      = aw_lp'(els_p);
    localparam logic [1:0]                 resp_okay   = 2'b00;
    localparam logic [1:0]                 resp_slverr = 2'b10;

    logic                    aw_full_q, w_full_q, bvalid_q, rvalid_q;
    logic [aw_lp-1:0]        awaddr_q;
    logic [dw_lp-1:0]        wdata_q, rdata_q;
    logic [strb_w_lp-1:0]    wstrb_q;
    logic [1:0]              bresp_q, rresp_q;
    logic [els_p*dw_lp-1:0]  reg_q;
    logic [els_p-1:0]        reg_w_v_q;

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic [aw_lp-1:0]        aw_idx_full, ar_idx_full;
    logic                    aw_ok, ar_ok;
    logic [lg_els_lp-1:0]    aw_idx, ar_idx;
    logic [els_p-1:0]        wr_sel;
    logic [dw_lp-1:0]        rd_word;
    logic                    unused_ok;

    assign s_axil_awready_o = ~reset_i & ~aw_full_q;
    assign s_axil_wready_o  = ~reset_i & ~w_full_q;
    assign s_axil_arready_o = ~reset_i & ~rvalid_q;

    assign aw_hs  = s_axil_awvalid_i & s_axil_awready_o;
    assign w_hs   = s_axil_wvalid_i & s_axil_wready_o;
    assign ar_hs  = s_axil_arvalid_i & s_axil_arready_o;
    // A pending response only blocks the commit if it is not draining this cycle
    assign commit = aw_full_q & w_full_q & (~bvalid_q | s_axil_bready_i);

    assign aw_idx_full = (awaddr_q - base_lp) >> lg_bytes_lp;
    assign ar_idx_full = (s_axil_araddr_i - base_lp) >> lg_bytes_lp;
    assign aw_ok       = (awaddr_q >= base_lp) && (aw_idx_full < els_lp);
    assign ar_ok       = (s_axil_araddr_i >= base_lp) && (ar_idx_full < els_lp);
    assign aw_idx      = aw_idx_full[lg_els_lp-1:0];
    assign ar_idx      = ar_idx_full[lg_els_lp-1:0];

    always_comb begin
        wr_sel  = '0;
        rd_word = '0;
        for (int i = 0; i < els_p; i++) begin
            if (aw_ok && (aw_idx == lg_els_lp'(i))) wr_sel[i] = 1'b1;
            if (ar_idx == lg_els_lp'(i)) rd_word = reg_q[i*dw_lp +: dw_lp];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            reg_q     <= '0;
            reg_w_v_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                awaddr_q  <= s_axil_awaddr_i;
            end else if (commit) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                wdata_q  <= s_axil_wdata_i;
                wstrb_q  <= s_axil_wstrb_i;
            end else if (commit) begin
                w_full_q <= 1'b0;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= aw_ok ? resp_okay : resp_slverr;
            end else if (s_axil_bready_i) begin
                bvalid_q <= 1'b0;
            end

            reg_w_v_q <= commit ? wr_sel : '0;
            for (int i = 0; i < els_p; i++) begin
                for (int b = 0; b < strb_w_lp; b++) begin
                    if (commit && wr_sel[i] && wstrb_q[b])
                        reg_q[i*dw_lp + 8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end

            // Read samples reg_q before any same-edge commit lands
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rresp_q  <= ar_ok ? resp_okay : resp_slverr;
                rdata_q  <= ar_ok ? rd_word : '0;
            end else if (s_axil_rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axil_bvalid_o = bvalid_q;
    assign s_axil_bresp_o  = bresp_q;
    assign s_axil_rvalid_o = rvalid_q;
    assign s_axil_rresp_o  = rresp_q;
    assign s_axil_rdata_o  = rdata_q;
    assign reg_o           = reg_q;
    assign reg_w_v_o       = reg_w_v_q;

    assign unused_ok = ^{s_axil_awprot_i, s_axil_arprot_i, aw_idx_full, ar_idx_full};

endmodule

// File: tb/tb_bsg_axil_reg_responder.sv
// tb/tb_bsg_axil_reg_responder.sv - self-checking bench for bsg_axil_reg_responder
module tb_bsg_axil_reg_responder;

    localparam int          W    = 32;
    localparam int          A    = 32;
    localparam int          E    = 8;
    localparam logic [31:0] BASE = 32'h1000;

    logic            clk_i, reset_i;
    logic [A-1:0]    awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [W-1:0]    wdata, rdata;
    logic [W/8-1:0]  wstrb;
    logic [1:0]      bresp, rresp;
    logic [E*W-1:0]  reg_o;
    logic [E-1:0]    reg_w_v;

    bsg_axil_reg_responder #(
        .axil_data_width_p(W), .axil_addr_width_p(A), .els_p(E), .base_addr_p(64'h1000)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot), .s_axil_awvalid_i(awvalid),
        .s_axil_awready_o(awready),
        .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
        .s_axil_wready_o(wready),
        .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
        .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot), .s_axil_arvalid_i(arvalid),
        .s_axil_arready_o(arready),
        .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
        .s_axil_rready_i(rready),
        .reg_o(reg_o), .reg_w_v_o(reg_w_v)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [E];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bresp;
        logic [7:0]  wv;
        logic [31:0] raddr;
        logic [1:0]  rresp;
        logic [31:0] rdata;
        int          hold;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] slice(input int i);
        return reg_o[i*32 +: 32];
    endfunction

    function automatic bit m_ok(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < E);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (m_ok(a)) begin
            idx = int'((a - BASE) >> 2);
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < E; i++)
            chk($sformatf("%s reg%0d", tag, i), slice(i), model[i]);
    endtask

    task automatic vec_write(input vec_t v, input string tag);
        awaddr = v.waddr; wdata = v.wdata; wstrb = v.wstrb;
        awvalid = 1; wvalid = 1; bready = 1;
        @(negedge clk_i);
        chk({tag, " awready"}, awready, 1);
        chk({tag, " wready"}, wready, 1);
        cyc();
        awvalid = 0; wvalid = 0;
        @(negedge clk_i);
        chk({tag, " bvalid t+1"}, bvalid, 0);
        cyc();
        @(negedge clk_i);
        chk({tag, " bvalid t+2"}, bvalid, 1);
        chk({tag, " bresp"}, bresp, v.bresp);
        chk({tag, " reg_w_v"}, reg_w_v, v.wv);
        chk({tag, " awready t+2"}, awready, 1);
        cyc();
        @(negedge clk_i);
        chk({tag, " bvalid drop"}, bvalid, 0);
        chk({tag, " reg_w_v drop"}, reg_w_v, 0);
        model_write(v.waddr, v.wdata, v.wstrb);
        cyc();
    endtask

    task automatic vec_read(input vec_t v, input string tag);
        araddr = v.raddr; arvalid = 1; rready = (v.hold == 0);
        @(negedge clk_i);
        chk({tag, " arready"}, arready, 1);
        cyc();
        arvalid = 0;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk_i);
            chk({tag, " rvalid held"}, rvalid, 1);
            chk({tag, " rdata held"}, rdata, v.rdata);
            chk({tag, " arready held"}, arready, 0);
            cyc();
        end
        rready = 1;
        @(negedge clk_i);
        chk({tag, " rvalid"}, rvalid, 1);
        chk({tag, " rdata"}, rdata, v.rdata);
        chk({tag, " rresp"}, rresp, v.rresp);
        cyc();
        @(negedge clk_i);
        chk({tag, " rvalid drop"}, rvalid, 0);
        chk({tag, " arready back"}, arready, 1);
        cyc();
    endtask

    task automatic rnd_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int  aw_d, w_d, bd, n;
        bit  aw_done, w_done, got, hs_aw, hs_w;
        logic [1:0] resp;
        aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); bd = $urandom_range(0, 3);
        aw_done = 0; w_done = 0; got = 0; n = 0; resp = 2'b11;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && n < 20) begin
            awvalid = !aw_done && (n >= aw_d);
            wvalid  = !w_done && (n >= w_d);
            @(negedge clk_i);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            cyc();
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            n++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) chk("rnd write accept timeout", 0, 1);
        n = 0;
        while (!got && n < 20) begin
            bready = (n >= bd);
            @(negedge clk_i);
            if (bvalid && bready) begin
                got = 1;
                resp = bresp;
            end
            cyc();
            n++;
        end
        bready = 1;
        if (!got) chk("rnd write response timeout", 0, 1);
        else chk($sformatf("rnd bresp @%h", a), resp, m_ok(a) ? 2'b00 : 2'b10);
        model_write(a, d, s);
    endtask

    task automatic rnd_read(input logic [31:0] a);
        int  rd, n;
        bit  got;
        logic [31:0] d;
        logic [1:0]  resp;
        rd = $urandom_range(0, 3); got = 0; n = 0; d = 0; resp = 2'b11;
        araddr = a; arvalid = 1; rready = 0;
        @(negedge clk_i);
        chk("rnd arready", arready, 1);
        cyc();
        arvalid = 0;
        while (!got && n < 20) begin
            rready = (n >= rd);
            @(negedge clk_i);
            if (rvalid && rready) begin
                got = 1;
                d = rdata;
                resp = rresp;
            end
            cyc();
            n++;
        end
        rready = 1;
        if (!got) chk("rnd read timeout", 0, 1);
        else begin
            chk($sformatf("rnd rresp @%h", a), resp, m_ok(a) ? 2'b00 : 2'b10);
            chk($sformatf("rnd rdata @%h", a), d,
                m_ok(a) ? model[int'((a - BASE) >> 2)] : 32'h0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h1004, 32'hDEADBEEF, 4'hF, 2'b00, 8'h02, 32'h1004, 2'b00, 32'hDEADBEEF, 0};
        vecs[1] = '{32'h1000, 32'hFFFFFFFF, 4'hF, 2'b00, 8'h01, 32'h1000, 2'b00, 32'hFFFFFFFF, 0};
        vecs[2] = '{32'h1000, 32'h11223344, 4'h5, 2'b00, 8'h01, 32'h1000, 2'b00, 32'hFF22FF44, 0};
        vecs[3] = '{32'h101C, 32'hA5A5A5A5, 4'hF, 2'b00, 8'h80, 32'h101C, 2'b00, 32'hA5A5A5A5, 4};
        vecs[4] = '{32'h1020, 32'h12345678, 4'hF, 2'b10, 8'h00, 32'h1020, 2'b10, 32'h00000000, 0};
        vecs[5] = '{32'h0FFC, 32'h12345678, 4'hF, 2'b10, 8'h00, 32'h0FFC, 2'b10, 32'h00000000, 1};
        vecs[6] = '{32'h1008, 32'hCAFEF00D, 4'h0, 2'b00, 8'h04, 32'h1008, 2'b00, 32'h00000000, 0};
        vecs[7] = '{32'h1006, 32'h0BADC0DE, 4'hC, 2'b00, 8'h02, 32'h1005, 2'b00, 32'h0BADBEEF, 2};
        for (int i = 0; i < E; i++) model[i] = 32'h0;

        reset_i = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 1; araddr = 0; arprot = 0; arvalid = 0; rready = 1;
        repeat (3) cyc();
        @(negedge clk_i);
        chk("reset awready", awready, 0);
        chk("reset wready", wready, 0);
        chk("reset arready", arready, 0);
        cyc();
        reset_i = 0;
        @(negedge clk_i);
        chk("post-reset awready", awready, 1);
        chk("post-reset wready", wready, 1);
        chk("post-reset arready", arready, 1);
        chk("post-reset bvalid", bvalid, 0);
        chk("post-reset rvalid", rvalid, 0);
        chk("post-reset bresp", bresp, 0);
        chk("post-reset rresp", rresp, 0);
        chk("post-reset rdata", rdata, 0);
        chk("post-reset reg_w_v", reg_w_v, 0);
        chk_regs("post-reset");
        cyc();

        for (int i = 0; i < 8; i++) begin
            vec_write(vecs[i], $sformatf("vec%0d wr", i));
            chk_regs($sformatf("vec%0d", i));
            vec_read(vecs[i], $sformatf("vec%0d rd", i));
        end

        // W leads AW by three cycles
        wdata = 32'h01020304; wstrb = 4'hF; wvalid = 1;
        @(negedge clk_i);
        chk("wfirst wready", wready, 1);
        cyc();
        wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("wfirst wready full", wready, 0);
            chk("wfirst no commit", bvalid, 0);
            cyc();
        end
        awaddr = 32'h1008; awvalid = 1;
        @(negedge clk_i);
        chk("wfirst awready", awready, 1);
        cyc();
        awvalid = 0;
        @(negedge clk_i);
        chk("wfirst bvalid t+1", bvalid, 0);
        cyc();
        @(negedge clk_i);
        chk("wfirst bvalid t+2", bvalid, 1);
        chk("wfirst bresp", bresp, 2'b00);
        chk("wfirst reg2", slice(2), 32'h01020304);
        model_write(32'h1008, 32'h01020304, 4'hF);
        cyc();

        // Back-pressured B channel with a second write queued behind it
        bready = 0;
        awaddr = 32'h1010; wdata = 32'h00000055; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk_i);
        cyc();
        awvalid = 0; wvalid = 0;
        @(negedge clk_i);
        cyc();
        awaddr = 32'h2000; wdata = 32'h99999999; awvalid = 1; wvalid = 1;
        @(negedge clk_i);
        chk("bstall first bvalid", bvalid, 1);
        chk("bstall first bresp", bresp, 2'b00);
        chk("bstall second awready", awready, 1);
        chk("bstall second wready", wready, 1);
        cyc();
        awvalid = 0; wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("bstall bvalid held", bvalid, 1);
            chk("bstall bresp held", bresp, 2'b00);
            chk("bstall awready", awready, 0);
            chk("bstall wready", wready, 0);
            cyc();
        end
        bready = 1;
        @(negedge clk_i);
        chk("bstall resp1 bvalid", bvalid, 1);
        chk("bstall resp1 bresp", bresp, 2'b00);
        cyc();
        @(negedge clk_i);
        chk("bstall resp2 bvalid", bvalid, 1);
        chk("bstall resp2 bresp", bresp, 2'b10);
        cyc();
        @(negedge clk_i);
        chk("bstall drained", bvalid, 0);
        model_write(32'h1010, 32'h00000055, 4'hF);
        model_write(32'h2000, 32'h99999999, 4'hF);
        chk_regs("bstall");
        cyc();

        // Read accepted in the commit cycle of a write to the same register
        awaddr = 32'h1010; wdata = 32'h00000066; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk_i);
        cyc();
        awvalid = 0; wvalid = 0;
        araddr = 32'h1010; arvalid = 1; rready = 1;
        @(negedge clk_i);
        chk("collide arready", arready, 1);
        cyc();
        arvalid = 0;
        @(negedge clk_i);
        chk("collide rvalid", rvalid, 1);
        chk("collide rdata old", rdata, 32'h00000055);
        chk("collide bvalid", bvalid, 1);
        chk("collide reg4 new", slice(4), 32'h00000066);
        model_write(32'h1010, 32'h00000066, 4'hF);
        cyc();

        // Reset with AW buffered
        awaddr = 32'h1000; awvalid = 1;
        @(negedge clk_i);
        cyc();
        awvalid = 0;
        reset_i = 1;
        @(negedge clk_i);
        chk("midreset awready", awready, 0);
        chk("midreset wready", wready, 0);
        chk("midreset arready", arready, 0);
        cyc();
        cyc();
        reset_i = 0;
        for (int i = 0; i < E; i++) model[i] = 32'h0;
        @(negedge clk_i);
        chk("midreset after awready", awready, 1);
        chk("midreset after bvalid", bvalid, 0);
        chk("midreset after rvalid", rvalid, 0);
        chk_regs("midreset");
        wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1;
        cyc();
        wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("midreset aw discarded", bvalid, 0);
            chk("midreset awready free", awready, 1);
            cyc();
        end
        awaddr = 32'h1000; awvalid = 1;
        cyc();
        awvalid = 0;
        cyc();
        @(negedge clk_i);
        chk("midreset commit bvalid", bvalid, 1);
        chk("midreset commit reg0", slice(0), 32'h00000077);
        model_write(32'h1000, 32'h00000077, 4'hF);
        cyc();

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = BASE - 32'd8 + 32'($urandom_range(0, 'h30));
            if ($urandom_range(0, 1) == 1) rnd_write(a, $urandom, 4'($urandom_range(0, 15)));
            else rnd_read(a);
        end
        chk_regs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_axil_reg_responder.md
Name: bsg_axil_reg_responder

Overview:
- AXI4-Lite subordinate (responder) endpoint that terminates manager-side AXI-Lite traffic, such as that issued by the debug bridge's master port.
- Implements a bank of els_p word-wide control/status registers. Register contents are exported to fabric logic, with a per-register write-strobe pulse.
- Serves as the standard target for debug/host MMIO in Zynq shells and as the bench partner for initiator blocks.

Parameters:
- axil_data_width_p, 32: data bus width; must be 32 or 64.
- axil_addr_width_p, 32: address bus width.
- els_p, 8: number of registers; must be at least 1.
- base_addr_p, 0: byte address of register 0; aligned to (axil_data_width_p/8).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- s_axil_awaddr_i  in  axil_addr_width_p  write address
- s_axil_awprot_i  in  3  ignored
- s_axil_awvalid_i  in  1  write address valid
- s_axil_awready_o  out  1  write address ready
- s_axil_wdata_i  in  axil_data_width_p  write data
- s_axil_wstrb_i  in  axil_data_width_p/8  byte strobes
- s_axil_wvalid_i  in  1  write data valid
- s_axil_wready_o  out  1  write data ready
- s_axil_bresp_o  out  2  write response
- s_axil_bvalid_o  out  1  write response valid
- s_axil_bready_i  in  1  write response ready
- s_axil_araddr_i  in  axil_addr_width_p  read address
- s_axil_arprot_i  in  3  ignored
- s_axil_arvalid_i  in  1  read address valid
- s_axil_arready_o  out  1  read address ready
- s_axil_rdata_o  out  axil_data_width_p  read data
- s_axil_rresp_o  out  2  read response
- s_axil_rvalid_o  out  1  read data valid
- s_axil_rready_i  in  1  read data ready
- reg_o  out  els_p*axil_data_width_p  register contents; register i occupies slice i
- reg_w_v_o  out  els_p  one-cycle pulse, bit i set in the cycle after register i is written

Behaviour:
- Clock/reset: one clock clk_i; reset_i is synchronous and active-high.
- Reset values: all registers are 0; AW/W buffers empty; bvalid, rvalid and reg_w_v_o are 0; bresp, rresp and rdata are 0.
- Ready gating: all ready outputs are 0 while reset_i is high. In the first cycle after reset deasserts, awready, wready and arready are 1.
- Address decode: offset = addr - base_addr_p; idx = offset >> lg(data_width/8); low offset bits are ignored.
  - In range when addr >= base_addr_p and idx < els_p.
  - Otherwise the access is an error: resp = SLVERR (2'b10); writes have no effect and reads return 0.
  - OKAY is 2'b00.
- Write buffers: AW and W are captured independently in one-entry buffers, in either order or in the same cycle.
  - awready_o = ~aw_full; wready_o = ~w_full.
- Write commit: commit occurs in any cycle where aw_full & w_full & (~bvalid | bready_i). At that clock edge:
  - Bytes whose wstrb bit is set are written to reg[idx]; other bytes are unchanged.
  - Both buffers empty.
  - bvalid is set with the decoded bresp.
  - reg_w_v_o[idx] pulses in the next cycle, but only for in-range writes.
  - wstrb = 0 still commits and produces OKAY plus a pulse.
- Write latency: AW and W accepted in cycle t → bvalid asserts in t+2 → awready/wready are high again in t+2. Sustained throughput is one write per 2 cycles.
- B channel: bvalid and bresp hold stable until bready_i. A commit in the same cycle as a B handshake is allowed (back-to-back responses).
- Read: arready_o = ~rvalid.
  - AR handshake in cycle t → rvalid, rdata and rresp are registered and visible in t+1.
  - These hold stable until rready_i; arready returns in the cycle after the R handshake.
- Read/write collision: a read accepted in the same cycle as a commit to the same register returns the pre-write value.
- Mid-operation reset: reset mid-transaction discards buffered AW/W and pending B/R responses and clears the registers.
- No AXI-Lite ordering exists between the read and write channels; they operate independently.

Test Plan:
- Write 0xDEADBEEF to base+0x4 with AW and W presented together, bready=1 → bvalid at t+2 with bresp=00; reg_o slice 1 = 0xDEADBEEF; reg_w_v_o=0b10 for one cycle.
- W presented 3 cycles before AW to base+0x8 → no commit until AW accepted; then bvalid 2 cycles later; reg 2 updated.
- wstrb=4'b0101 with data 0x11223344 over reg 0 = 0xFFFFFFFF → reg 0 = 0xFF22FF44.
- Read base+0x1C (idx 7) after writing 0xA5A5A5A5, rready held low for 4 cycles → rvalid/rdata stable 0xA5A5A5A5; arready stays 0 until the handshake.
- Write and read to base+0x20 (out of range, els_p=8) → bresp=10, rresp=10, rdata=0; no reg_o change; reg_w_v_o stays 0.
- Hold bready=0 while issuing a second write → second AW/W captured, but commit stalls until bready rises; then two consecutive B responses with no loss.
- Assert reset_i mid-write (AW buffered) → readies 0 during reset; afterwards bvalid=0, registers 0 and buffers empty.
